inet_chksum_accum: RTL and testbench

Streaming accumulator directly upstream of `inet_chksum`. Consumes a packet as a sequence of 32-bit words with valid/ready handshake. Keeps two independent 16-bit one's-complement running sums, one for the upper halfwords and one for the lower halfwords. At end of packet it presents them packed as one 32-bit word. That word connects straight to `inet_chksum.data`, which folds the two halves and complements them to produce the final Internet checksum.

---
 rtl/inet_chksum_accum_pkg.sv | 22 ++
 rtl/inet_chksum_accum_if.sv | 25 ++
 rtl/inet_chksum_accum_ones_add16.sv | 16 +
 rtl/inet_chksum_accum.sv | 90 +++++++++
 tb/tb_inet_chksum_accum.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/inet_chksum_accum_pkg.sv
// Shared types and helpers for the Internet checksum accumulator path.
// The halfword width and the byte-enable masking are used by the accumulator and a future verify stage.
package inet_chksum_pkg;

  localparam int unsigned CHK_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  function automatic logic [31:0] keep_mask(input logic [31:0] data, input logic [3:0] keep);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m[i*8 +: 8] = keep[i] ? data[i*8 +: 8] : 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/inet_chksum_accum_if.sv
// Word-stream input and result output of inet_chksum_accum.
// The master drives words and out_ready; the slave (accumulator) answers.
interface inet_chksum_accum_if #(
  parameter int unsigned WORD_CNT_W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_data;
  logic [3:0]            in_keep;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_sum;
  logic [WORD_CNT_W-1:0] out_words;

  modport master (
    output in_valid, in_data, in_keep, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_words
  );

  modport slave (
    input  in_valid, in_data, in_keep, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_words
  );
endinterface

// File: rtl/inet_chksum_accum_ones_add16.sv
// 16-bit one's-complement adder with end-around carry.
// A non-zero operand never yields 0x0000, so 0xFFFF + 0x0000 stays 0xFFFF.
module ones_add16
  import inet_chksum_pkg::*;
(
  input  logic [CHK_W-1:0] a,
  input  logic [CHK_W-1:0] b,
  output logic [CHK_W-1:0] y
);
  logic [CHK_W:0] s;

  always_comb begin
    s = {1'b0, a} + {1'b0, b};
    y = s[CHK_W-1:0] + {{(CHK_W-1){1'b0}}, s[CHK_W]};
  end
endmodule

// File: rtl/inet_chksum_accum.sv
// Streaming accumulator: two independent one's-complement halfword sums per packet,
// presented as {hi, lo} with a saturating word count at end of packet.
module inet_chksum_accum
  import inet_chksum_pkg::*;
#(
  parameter int unsigned WORD_CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  inet_chksum_accum_if.slave bus
);
  state_e                state_q, state_d;
  logic [CHK_W-1:0]      hi_q, hi_d, lo_q, lo_d, hi_sum, lo_sum;
  logic [WORD_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WORD_CNT_W-1:0] out_words_q, out_words_d;
  logic [31:0]           out_sum_q, out_sum_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           masked;
  logic                  accept;

  ones_add16 u_add_hi (.a(hi_q), .b(masked[31:16]), .y(hi_sum));
  ones_add16 u_add_lo (.a(lo_q), .b(masked[15:0]),  .y(lo_sum));

  assign bus.in_ready  = (state_q != DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_words = out_words_q;

  always_comb begin
    masked      = keep_mask(bus.in_data, bus.in_keep);
    accept      = bus.in_valid && (state_q != DONE);
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + WORD_CNT_W'(1);
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_words_d = out_words_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          hi_d  = hi_sum;
          lo_d  = lo_sum;
          cnt_d = cnt_inc;
          if (bus.in_last) begin
            state_d     = DONE;
            out_sum_d   = {hi_sum, lo_sum};
            out_words_d = cnt_inc;
            out_valid_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        // Accumulators clear on the handshake so IDLE always starts from zero.
        if (bus.out_ready) begin
          state_d     = IDLE;
          hi_d        = '0;
          lo_d        = '0;
          cnt_d       = '0;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_words_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_words_q <= out_words_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_inet_chksum_accum.sv
// Directed bench for inet_chksum_accum: scoreboard of expected results plus
// immediate checks on handshake timing, backpressure, reset and counter saturation.
module tb_inet_chksum_accum;

  typedef struct packed {
    logic [31:0] sum;
    logic [15:0] words;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  exp_t sb[$];
  exp_t mon_e;

  logic [31:0] m_hi, m_lo;
  int          m_words;
  logic [31:0] held_sum;

  always #5 clk = ~clk;

  inet_chksum_accum_if #(.WORD_CNT_W(16)) if0 ();
  inet_chksum_accum_if #(.WORD_CNT_W(2))  if1 ();

  inet_chksum_accum #(.WORD_CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(if0.slave));
  inet_chksum_accum #(.WORD_CNT_W(2))  u_sat (.clk(clk), .rst(rst), .bus(if1.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fold(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    while ((v >> 16) != 0) v = (v & 32'h0000_FFFF) + (v >> 16);
    return v;
  endfunction

  function automatic logic [31:0] bench_mask(input logic [31:0] d, input logic [3:0] k);
    logic [31:0] m;
    m = 32'h0;
    if (k[3]) m[31:24] = d[31:24];
    if (k[2]) m[23:16] = d[23:16];
    if (k[1]) m[15:8]  = d[15:8];
    if (k[0]) m[7:0]   = d[7:0];
    return m;
  endfunction

  task automatic model_clear();
    m_hi = 0; m_lo = 0; m_words = 0;
  endtask

  // One beat on if0, accepted at the next rising edge; model is updated alongside.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic last);
    logic [31:0] mk;
    exp_t e;
    if0.in_valid = 1'b1;
    if0.in_data  = d;
    if0.in_keep  = k;
    if0.in_last  = last;
    check("in_ready_beat", 32'(if0.in_ready), 32'd1);
    mk = bench_mask(d, k);
    m_hi = m_hi + {16'h0, mk[31:16]};
    m_lo = m_lo + {16'h0, mk[15:0]};
    m_words++;
    if (last) begin
      e.sum   = {fold(m_hi)[15:0], fold(m_lo)[15:0]};
      e.words = (m_words > 65535) ? 16'hFFFF : 16'(m_words);
      sb.push_back(e);
      model_clear();
    end
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
  endtask

  // Called #1 after the last-beat edge with out_ready=1.
  task automatic finish_pkt(input string tag, input logic [31:0] exp_sum, input logic [31:0] exp_words);
    check({tag, "_ov_rise"}, 32'(if0.out_valid), 32'd1);
    check({tag, "_in_ready_done"}, 32'(if0.in_ready), 32'd0);
    check({tag, "_sum"}, if0.out_sum, exp_sum);
    check({tag, "_words"}, 32'(if0.out_words), exp_words);
    @(posedge clk); #1;
    check({tag, "_ov_fall"}, 32'(if0.out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(if0.in_ready), 32'd1);
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && if0.out_valid && if0.out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_sum", if0.out_sum, mon_e.sum);
        check("sb_words", 32'(if0.out_words), 32'(mon_e.words));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if0.in_valid = 1'b0; if0.in_data = '0; if0.in_keep = '0; if0.in_last = 1'b0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.in_keep = '0; if1.in_last = 1'b0; if1.out_ready = 1'b1;
    model_clear();

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 32'(if0.in_ready), 32'd1);
    check("rst_out_valid", 32'(if0.out_valid), 32'd0);
    check("rst_out_sum", if0.out_sum, 32'h0);
    check("rst_out_words", 32'(if0.out_words), 32'd0);
    check("rst_sat_words", 32'(if1.out_words), 32'd0);

    send_beat(32'h4500_0073, 4'hF, 1'b1);
    finish_pkt("single", 32'h4500_0073, 32'd1);

    send_beat(32'hFFFF_0001, 4'hF, 1'b0);
    send_beat(32'h0001_FFFF, 4'hF, 1'b1);
    finish_pkt("eac", 32'h0001_0001, 32'd2);

    send_beat(32'h0001_0002, 4'hF, 1'b0);
    send_beat(32'h1234_5678, 4'b1100, 1'b1);
    finish_pkt("keep", 32'h1235_0002, 32'd2);

    // 0xFFFF + 0 must stay 0xFFFF; zero-keep beat still counts.
    send_beat(32'h0000_FFFF, 4'hF, 1'b0);
    send_beat(32'hFFFF_FFFF, 4'h0, 1'b1);
    finish_pkt("ffff_plus_zero", 32'h0000_FFFF, 32'd2);

    if0.out_ready = 1'b0;
    send_beat(32'hABCD_1234, 4'hF, 1'b1);
    held_sum = 32'hABCD_1234;
    if0.in_valid = 1'b1; if0.in_data = 32'hFFFF_FFFF; if0.in_keep = 4'hF; if0.in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", 32'(if0.out_valid), 32'd1);
      check("bp_in_ready", 32'(if0.in_ready), 32'd0);
      check("bp_sum_stable", if0.out_sum, held_sum);
      @(posedge clk); #1;
    end
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    check("bp_ov_fall", 32'(if0.out_valid), 32'd0);
    check("bp_sb_drained", 32'(sb.size()), 32'd0);
    send_beat(32'h0000_0001, 4'hF, 1'b1);
    finish_pkt("after_bp", 32'h0000_0001, 32'd1);

    send_beat(32'h1111_2222, 4'hF, 1'b0);
    send_beat(32'h3333_4444, 4'hF, 1'b0);
    rst = 1'b1;
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(if0.in_ready), 32'd1);
    check("midrst_out_valid", 32'(if0.out_valid), 32'd0);
    check("midrst_out_sum", if0.out_sum, 32'h0);
    send_beat(32'h0000_FFFF, 4'hF, 1'b1);
    finish_pkt("after_rst", 32'h0000_FFFF, 32'd1);

    for (int i = 0; i < 5; i++) begin
      if1.in_valid = 1'b1; if1.in_data = 32'h0; if1.in_keep = 4'hF; if1.in_last = (i == 4);
      check("sat_in_ready", 32'(if1.in_ready), 32'd1);
      @(posedge clk); #1;
    end
    if1.in_valid = 1'b0;
    check("sat_out_valid", 32'(if1.out_valid), 32'd1);
    check("sat_words", 32'(if1.out_words), 32'd3);
    check("sat_sum", if1.out_sum, 32'h0);
    @(posedge clk); #1;
    check("sat_ov_fall", 32'(if1.out_valid), 32'd0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
